// File: rtl/dt_pkg.sv
// dt_engine shared types: FSM states, metric codes and the neighbour table.
// The table is indexed by {backward pass, metric, slot}.
package dt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FW_FETCH,
        FW_RD,
        FW_WR,
        FW_END,
        BW_CTR,
        BW_RD,
        BW_WR,
        DONE
    } dt_state_e;

    localparam logic DT_CHESS = 1'b0;
    localparam logic DT_CITY  = 1'b1;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } nb_off_t;

    localparam logic signed [1:0] NB_M = -2'sd1;
    localparam logic signed [1:0] NB_Z = 2'sd0;
    localparam logic signed [1:0] NB_P = 2'sd1;

    // City-block rows only use the first two slots; the rest are padding.
    localparam nb_off_t NB_TAB [16] = '{
        '{NB_M, NB_M}, '{NB_Z, NB_M}, '{NB_P, NB_M}, '{NB_M, NB_Z},
        '{NB_Z, NB_M}, '{NB_M, NB_Z}, '{NB_Z, NB_Z}, '{NB_Z, NB_Z},
        '{NB_P, NB_Z}, '{NB_M, NB_P}, '{NB_Z, NB_P}, '{NB_P, NB_P},
        '{NB_P, NB_Z}, '{NB_Z, NB_P}, '{NB_Z, NB_Z}, '{NB_Z, NB_Z}
    };

    function automatic logic [2:0] n_nb(input logic m);
        return (m == DT_CITY) ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/dt_mem_if.sv
// ROM/RAM port bundle between dt_engine and the sti_ROM / res_RAM models.
interface dt_mem_if #(
    parameter int WORD_W = 16,
    parameter int DIST_W = 8,
    parameter int SA_W   = 10,
    parameter int RA_W   = 14
);
    logic              sti_rd;
    logic [SA_W-1:0]   sti_addr;
    logic [WORD_W-1:0] sti_di;
    logic              res_rd;
    logic              res_wr;
    logic [RA_W-1:0]   res_addr;
    logic [DIST_W-1:0] res_do;
    logic [DIST_W-1:0] res_di;

    modport master (
        output sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
        input  sti_di, res_di
    );

    modport slave (
        input  sti_rd, sti_addr, res_rd, res_wr, res_addr, res_do,
        output sti_di, res_di
    );
endinterface

// File: rtl/dt_min_sat.sv
// Running minimum of two distances plus a saturating +1 of that minimum.
module dt_min_sat #(
    parameter int DIST_W = 8
) (
    input  logic [DIST_W-1:0] acc_i,
    input  logic [DIST_W-1:0] val_i,
    output logic [DIST_W-1:0] min_o,
    output logic [DIST_W-1:0] inc_o
);
    logic [DIST_W:0] sum;

    always_comb begin
        min_o = (val_i < acc_i) ? val_i : acc_i;
        sum   = {1'b0, min_o} + (DIST_W+1)'(1);
        inc_o = sum[DIST_W] ? '1 : sum[DIST_W-1:0];
    end
endmodule

// File: rtl/dt_engine.sv
// Two-pass chessboard / city-block distance transform, sti_ROM -> res_RAM.
// Forward raster pass then reverse raster pass, restartable via start.
module dt_engine
    import dt_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int WORD_W = 16,
    parameter int DIST_W = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     metric,
    dt_mem_if.master mem,
    output logic     fwpass_finish,
    output logic     done
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWORD = NPIX / WORD_W;
    localparam int AW    = $clog2(NPIX);
    localparam int SW    = $clog2(NWORD);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int BW    = $clog2(WORD_W);

    dt_state_e         state_q, state_d;
    logic              metric_q, metric_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [AW-1:0]     p_q, p_d;
    logic [SW-1:0]     w_q, w_d;
    logic [BW-1:0]     b_q, b_d;
    logic [1:0]        k_q, k_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [DIST_W-1:0] min_q, min_d;
    logic [DIST_W-1:0] ctr_q, ctr_d;

    nb_off_t           off;
    logic              bw_pass;
    logic              nb_ok;
    logic              k_last;
    logic              bw_step;
    logic signed [31:0] nx, ny, na;
    logic [DIST_W-1:0] rd_val;
    logic [DIST_W-1:0] run_min;
    logic [DIST_W-1:0] run_inc;
    logic [DIST_W-1:0] bw_val;

    dt_min_sat #(.DIST_W(DIST_W)) u_min (
        .acc_i (min_q),
        .val_i (rd_val),
        .min_o (run_min),
        .inc_o (run_inc)
    );

    // Neighbour position; out-of-image slots still take their cycle.
    always_comb begin
        bw_pass = (state_q == BW_CTR) || (state_q == BW_RD) ||
                  (state_q == BW_WR);
        off     = NB_TAB[{bw_pass, metric_q, k_q}];
        nx      = $signed(32'(x_q)) + 32'($signed(off.dx));
        ny      = $signed(32'(y_q)) + 32'($signed(off.dy));
        na      = $signed(32'(p_q)) + 32'($signed(off.dy)) * IMG_W +
                  32'($signed(off.dx));
        nb_ok   = (nx >= 0) && (nx < IMG_W) && (ny >= 0) && (ny < IMG_H);
        k_last  = (k_q == 2'(n_nb(metric_q) - 3'd1));
        bw_val  = (ctr_q < run_inc) ? ctr_q : run_inc;
    end

    always_comb begin
        state_d  = state_q;
        metric_d = metric_q;
        x_d      = x_q;
        y_d      = y_q;
        p_d      = p_q;
        w_d      = w_q;
        b_d      = b_q;
        k_d      = k_q;
        sreg_d   = sreg_q;
        min_d    = '1;
        ctr_d    = ctr_q;
        rd_val   = '1;
        bw_step  = 1'b0;

        mem.sti_rd    = 1'b0;
        mem.sti_addr  = '0;
        mem.res_rd    = 1'b0;
        mem.res_wr    = 1'b0;
        mem.res_addr  = '0;
        mem.res_do    = '0;
        fwpass_finish = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d  = FW_FETCH;
                    metric_d = metric;
                    x_d      = '0;
                    y_d      = '0;
                    p_d      = '0;
                    w_d      = '0;
                    b_d      = '0;
                    k_d      = '0;
                end
            end
            FW_FETCH: begin
                mem.sti_rd   = 1'b1;
                mem.sti_addr = w_q;
                sreg_d       = mem.sti_di;
                w_d          = w_q + SW'(1);
                k_d          = '0;
                state_d      = mem.sti_di[WORD_W-1] ? FW_RD : FW_WR;
            end
            FW_RD, BW_RD: begin
                mem.res_rd   = nb_ok;
                mem.res_addr = nb_ok ? AW'(na) : '0;
                rd_val       = nb_ok ? mem.res_di : '0;
                min_d        = run_min;
                k_d          = k_q + 2'd1;
                if (k_last) begin
                    state_d = (state_q == FW_RD) ? FW_WR : BW_WR;
                end
            end
            FW_WR: begin
                mem.res_wr   = 1'b1;
                mem.res_addr = p_q;
                mem.res_do   = sreg_q[WORD_W-1] ? run_inc : '0;
                sreg_d       = sreg_q << 1;
                k_d          = '0;
                if (p_q == AW'(NPIX - 1)) begin
                    state_d = FW_END;
                end else begin
                    p_d = p_q + AW'(1);
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                    if (b_q == BW'(WORD_W - 1)) begin
                        b_d     = '0;
                        state_d = FW_FETCH;
                    end else begin
                        b_d     = b_q + BW'(1);
                        state_d = sreg_q[WORD_W-2] ? FW_RD : FW_WR;
                    end
                end
            end
            FW_END: begin
                fwpass_finish = 1'b1;
                state_d       = BW_CTR;
            end
            BW_CTR: begin
                mem.res_rd   = 1'b1;
                mem.res_addr = p_q;
                k_d          = '0;
                if (mem.res_di == '0) begin
                    bw_step = 1'b1;
                end else begin
                    ctr_d   = mem.res_di;
                    state_d = BW_RD;
                end
            end
            BW_WR: begin
                mem.res_wr   = 1'b1;
                mem.res_addr = p_q;
                mem.res_do   = bw_val;
                bw_step      = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (bw_step) begin
            if (p_q == '0) begin
                state_d = DONE;
            end else begin
                state_d = BW_CTR;
                p_d     = p_q - AW'(1);
                if (x_q == '0) begin
                    x_d = XW'(IMG_W - 1);
                    y_d = y_q - YW'(1);
                end else begin
                    x_d = x_q - XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            metric_q <= DT_CHESS;
            x_q      <= '0;
            y_q      <= '0;
            p_q      <= '0;
            w_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            sreg_q   <= '0;
            min_q    <= '1;
            ctr_q    <= '0;
        end else begin
            state_q  <= state_d;
            metric_q <= metric_d;
            x_q      <= x_d;
            y_q      <= y_d;
            p_q      <= p_d;
            w_q      <= w_d;
            b_q      <= b_d;
            k_q      <= k_d;
            sreg_q   <= sreg_d;
            min_q    <= min_d;
            ctr_q    <= ctr_d;
        end
    end
endmodule

// File: tb/tb_dt_engine.sv
// Bench for dt_engine on a 32x16 image, 8-bit ROM words, 3-bit distances.
// Golden image = brute-force nearest-background search, clamped to 7.
module tb_dt_engine;
    import dt_pkg::*;

    localparam int W     = 32;
    localparam int H     = 16;
    localparam int WW    = 8;
    localparam int DW    = 3;
    localparam int NPIX  = W * H;
    localparam int NWORD = NPIX / WW;
    localparam int SAW   = $clog2(NWORD);
    localparam int RAW   = $clog2(NPIX);
    localparam int DMAX  = (1 << DW) - 1;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic start  = 1'b0;
    logic metric = 1'b0;
    logic fwpass_finish;
    logic done;
    logic scrub  = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] rom  [NWORD];
    logic [DW-1:0] ram  [NPIX];
    logic [DW-1:0] snap [NPIX];
    bit            pix  [NPIX];
    int            gold [NPIX];

    dt_mem_if #(.WORD_W(WW), .DIST_W(DW), .SA_W(SAW), .RA_W(RAW)) mi ();

    dt_engine #(
        .IMG_W (W),
        .IMG_H (H),
        .WORD_W(WW),
        .DIST_W(DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .metric       (metric),
        .mem          (mi),
        .fwpass_finish(fwpass_finish),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mi.sti_rd) mi.sti_di <= rom[mi.sti_addr];
        if (mi.res_rd) mi.res_di <= ram[mi.res_addr];
    end

    // Garbage fill before a run shows the forward pass writes every word.
    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < NPIX; i++) ram[i] <= DW'($urandom);
        end else if (mi.res_wr) begin
            ram[mi.res_addr] <= mi.res_do;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_pix();
        for (int i = 0; i < NPIX; i++) pix[i] = 1'b0;
    endtask

    task automatic set_rect(input int x0, y0, x1, y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) pix[y*W + x] = 1'b1;
    endtask

    task automatic rand_pix(input int pct);
        for (int i = 0; i < NPIX; i++)
            pix[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic load_rom();
        for (int w = 0; w < NWORD; w++)
            for (int i = 0; i < WW; i++) rom[w][WW-1-i] = pix[w*WW + i];
    endtask

    function automatic int n_obj();
        int n = 0;
        for (int i = 0; i < NPIX; i++) n += int'(pix[i]);
        return n;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic make_gold(input logic m);
        int x, y, d, dd, ax, ay;
        for (int i = 0; i < NPIX; i++) begin
            if (!pix[i]) begin
                gold[i] = 0;
                continue;
            end
            x = i % W;
            y = i / W;
            d = x + 1;
            if (y + 1 < d) d = y + 1;
            if (W - x < d) d = W - x;
            if (H - y < d) d = H - y;
            for (int j = 0; j < NPIX; j++) begin
                if (pix[j]) continue;
                ax = iabs(j % W - x);
                ay = iabs(j / W - y);
                dd = m ? ax + ay : ((ax > ay) ? ax : ay);
                if (dd < d) d = dd;
            end
            gold[i] = (d > DMAX) ? DMAX : d;
        end
    endtask

    task automatic cmp_img(input string tag, input logic m);
        int nerr = 0;
        int first = -1;
        make_gold(m);
        for (int i = 0; i < NPIX; i++) begin
            if (int'(ram[i]) != gold[i]) begin
                nerr++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("  %s first bad pixel %0d: ram=%0d model=%0d",
                     tag, first, ram[first], gold[first]);
        check({tag, ":img"}, nerr, 0);
    endtask

    task automatic run_dt(input logic m, input string tag,
                          output int fw_rd, output int bw_rd);
        int nn, nobj, cyc, fw_at, dn_at, coll;
        nn    = m ? 2 : 4;
        nobj  = n_obj();
        fw_rd = 0;
        bw_rd = 0;
        fw_at = -1;
        dn_at = -1;
        coll  = 0;
        load_rom();
        @(negedge clk);
        scrub = 1'b1;
        @(negedge clk);
        scrub  = 1'b0;
        start  = 1'b1;
        metric = m;
        @(negedge clk);
        start  = 1'b0;
        metric = $urandom_range(0, 1);
        cyc    = 1;
        check({tag, ":first_fetch"},
              32'(mi.sti_rd && (mi.sti_addr == '0)), 1);
        while (dn_at < 0 && cyc < 20000) begin
            if (mi.res_rd && mi.res_wr) coll++;
            if (mi.res_rd) begin
                if (fw_at < 0) fw_rd++;
                else bw_rd++;
            end
            if (fwpass_finish) fw_at = cyc;
            if (done) dn_at = cyc;
            @(negedge clk);
            cyc++;
        end
        check({tag, ":fw_cycle"}, fw_at, NWORD + NPIX + nn*nobj + 1);
        check({tag, ":done_cycle"}, dn_at,
              NWORD + NPIX + nn*nobj + 1 + NPIX + (nn+1)*nobj + 1);
        check({tag, ":rd_wr_overlap"}, coll, 0);
        check({tag, ":done_idle"},
              32'({done, mi.sti_rd, mi.res_rd, mi.res_wr}), 32'(4'b1000));
        cmp_img(tag, m);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({mi.sti_rd, mi.res_rd, mi.res_wr, fwpass_finish,
                        done, mi.sti_addr, mi.res_addr, mi.res_do}), 0);
    endtask

    initial begin
        int fr, br, nerr;
        #2;
        check_quiet("reset_outputs");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        clear_pix();
        run_dt(DT_CHESS, "zero", fr, br);

        clear_pix();
        pix[5*W + 5] = 1'b1;
        run_dt(DT_CHESS, "single", fr, br);
        check("single:px", 32'(ram[5*W + 5]), 1);

        clear_pix();
        set_rect(10, 10, 14, 14);
        run_dt(DT_CHESS, "blk_chess", fr, br);
        check("blk_chess:centre", 32'(ram[12*W + 12]), 3);
        check("blk_chess:ring", 32'(ram[11*W + 11]), 2);
        check("blk_chess:edge", 32'(ram[10*W + 10]), 1);
        run_dt(DT_CITY, "blk_city", fr, br);
        check("blk_city:centre", 32'(ram[12*W + 12]), 3);
        check("blk_city:11_11", 32'(ram[11*W + 11]), 2);
        check("blk_city:12_11", 32'(ram[11*W + 12]), 2);

        // Only (0,0) is object: all forward slots fall outside the image,
        // backward reads every centre plus E, S, SE of (0,0).
        clear_pix();
        pix[0] = 1'b1;
        run_dt(DT_CHESS, "corner", fr, br);
        check("corner:px", 32'(ram[0]), 1);
        check("corner:fw_reads", fr, 0);
        check("corner:bw_reads", br, NPIX + 3);

        clear_pix();
        set_rect(8, 0, 22, 14);
        run_dt(DT_CHESS, "sat", fr, br);
        check("sat:centre", 32'(ram[7*W + 15]), DMAX);

        for (int r = 0; r < 4; r++) begin
            rand_pix(55 + 10*r);
            run_dt(logic'(r[0]), $sformatf("rand%0d", r), fr, br);
        end

        rand_pix(70);
        load_rom();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet("midrun_reset");
        repeat (2) @(negedge clk);
        check_quiet("midrun_hold");
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_idle", 32'({done, mi.sti_rd, mi.res_wr}), 0);

        rand_pix(75);
        run_dt(DT_CITY, "restart", fr, br);
        for (int i = 0; i < NPIX; i++) snap[i] = ram[i];
        run_dt(DT_CITY, "again", fr, br);
        nerr = 0;
        for (int i = 0; i < NPIX; i++) if (ram[i] !== snap[i]) nerr++;
        check("again:same", nerr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
